tcp_stream_encoder: RTL and testbench

Parametrised successor to the TCP segment encoder. It builds a complete TCP segment (header, options, payload) as a 32-bit word stream for the IP framing stage. It computes the full RFC 793 checksum, including the IPv4 pseudo-header, and adds consumer backpressure plus a payload-pull handshake. It sits between the socket payload buffer and the IP encoder.

---
 rtl/tcp_stream_encoder.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_tcp_stream_encoder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_stream_encoder.sv
// rtl/tcp_stream_encoder.sv - TCP segment word-stream encoder with checksum; TCP_ENC_TIMESTAMP_EN enables the timestamp option
module tcp_stream_encoder #(
  parameter int LEN_W      = 16,
  parameter int PSEUDO_HDR = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      src_port,
  input  logic [15:0]      dest_port,
  input  logic [31:0]      seq_num,
  input  logic [31:0]      ack_num,
  input  logic             f_urg,
  input  logic             f_ack,
  input  logic             f_psh,
  input  logic             f_rst,
  input  logic             f_syn,
  input  logic             f_fin,
  input  logic [15:0]      window,
  input  logic [15:0]      urg_ptr,
  input  logic [31:0]      src_ip,
  input  logic [31:0]      dst_ip,
  input  logic [2:0]       option_av,
  input  logic [15:0]      mss,
  input  logic [7:0]       scale_wnd,
  input  logic [63:0]      time_stp,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      data,
  input  logic             data_av,
  output logic             data_rd,
  input  logic             out_rdy,
  output logic [31:0]      pkg_data,
  output logic             wr_en,
  output logic [15:0]      checksum_out,
  output logic             fin
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_OPT, S_DATA, S_FOLD1, S_FOLD2, S_DONE} state_t;

  localparam logic [LEN_W-1:0] REM_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      pkg_q, pkg_d;
  logic             wr_en_q, wr_en_d;
  logic             fin_q, fin_d;
  logic [15:0]      csum_q, csum_d;

  logic [15:0]      src_port_q, dest_port_q, window_q, urg_ptr_q, mss_q;
  logic [31:0]      seq_q, ack_q, src_ip_q, dst_ip_q;
  logic [5:0]       flags_q;
  logic [7:0]       scale_q;
  logic [LEN_W-1:0] len_q;
  logic             opt_mss_q, opt_ws_q, opt_ts;

  logic [2:0]       opt_n;
  logic [3:0]       doff;
  logic [LEN_W:0]   len_p3, tcp_len;
  logic [LEN_W-1:0] data_words;
  logic [31:0]      pseudo_sum, fold_acc;
  logic [31:0]      hdr_word, opt_word, data_word, word;
  logic             word_vld;
  logic             ld;

  // Capture the segment description when a segment is started from IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_port_q  <= '0;
      dest_port_q <= '0;
      seq_q       <= '0;
      ack_q       <= '0;
      flags_q     <= '0;
      window_q    <= '0;
      urg_ptr_q   <= '0;
      src_ip_q    <= '0;
      dst_ip_q    <= '0;
      opt_mss_q   <= 1'b0;
      opt_ws_q    <= 1'b0;
      mss_q       <= '0;
      scale_q     <= '0;
      len_q       <= '0;
    end else if (state_q == S_IDLE && start) begin
      src_port_q  <= src_port;
      dest_port_q <= dest_port;
      seq_q       <= seq_num;
      ack_q       <= ack_num;
      flags_q     <= {f_urg, f_ack, f_psh, f_rst, f_syn, f_fin};
      window_q    <= window;
      urg_ptr_q   <= urg_ptr;
      src_ip_q    <= src_ip;
      dst_ip_q    <= dst_ip;
      opt_mss_q   <= option_av[0];
      opt_ws_q    <= option_av[1];
      mss_q       <= mss;
      scale_q     <= scale_wnd;
      len_q       <= len;
    end
  end

`ifdef TCP_ENC_TIMESTAMP_EN
  logic        opt_ts_q;
  logic [63:0] ts_q;
  logic [2:0]  ts_idx;

  // Capture the timestamp option alongside the rest of the segment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opt_ts_q <= 1'b0;
      ts_q     <= '0;
    end else if (state_q == S_IDLE && start) begin
      opt_ts_q <= option_av[2];
      ts_q     <= time_stp;
    end
  end

  assign opt_ts = opt_ts_q;
  assign ts_idx = idx_q - ({2'b0, opt_mss_q} + {2'b0, opt_ws_q});
`else
  logic unused_ts;
  assign opt_ts    = 1'b0;
  assign unused_ts = ^{time_stp, option_av[2]};
`endif

  assign opt_n      = {2'b0, opt_mss_q} + {2'b0, opt_ws_q} + (opt_ts ? 3'd3 : 3'd0);
  assign doff       = 4'd5 + {1'b0, opt_n};
  assign len_p3     = {1'b0, len_q} + {{(LEN_W-1){1'b0}}, 2'b11};
  assign data_words = {1'b0, len_p3[LEN_W:2]};
  assign tcp_len    = {{(LEN_W-5){1'b0}}, doff, 2'b00} + {1'b0, len_q};
  assign pseudo_sum = {16'h0, src_ip_q[31:16]} + {16'h0, src_ip_q[15:0]}
                    + {16'h0, dst_ip_q[31:16]} + {16'h0, dst_ip_q[15:0]}
                    + 32'd6 + {{(31-LEN_W){1'b0}}, tcp_len};
  assign fold_acc   = {16'h0, acc_q[15:0]} + {16'h0, acc_q[31:16]};
  // The output register may take a new word when it is empty or being drained
  assign ld         = !wr_en_q || out_rdy;

  // Fixed header word selected by the word index
  always_comb begin
    hdr_word = 32'h0;
    case (idx_q)
      3'd0:    hdr_word = {src_port_q, dest_port_q};
      3'd1:    hdr_word = seq_q;
      3'd2:    hdr_word = ack_q;
      3'd3:    hdr_word = {doff, 6'b0, flags_q, window_q};
      3'd4:    hdr_word = {16'h0000, urg_ptr_q};
      default: hdr_word = 32'h0;
    endcase
  end

  // Option words are packed back to back in MSS, window-scale, timestamp order
  always_comb begin
    opt_word = 32'h0;
    if (opt_mss_q && idx_q == 3'd0) begin
      opt_word = {16'h0204, mss_q};
    end else if (opt_ws_q && idx_q == {2'b0, opt_mss_q}) begin
      opt_word = {24'h010303, scale_q};
    end
`ifdef TCP_ENC_TIMESTAMP_EN
    else if (opt_ts) begin
      case (ts_idx)
        3'd0:    opt_word = 32'h0101080A;
        3'd1:    opt_word = ts_q[63:32];
        3'd2:    opt_word = ts_q[31:0];
        default: opt_word = 32'h0;
      endcase
    end
`endif
  end

  // Zero the bytes of the final payload word that lie beyond len
  always_comb begin
    data_word = data;
    if (rem_q == REM_ONE) begin
      case (len_q[1:0])
        2'd1:    data_word = {data[31:24], 24'h0};
        2'd2:    data_word = {data[31:16], 16'h0};
        2'd3:    data_word = {data[31:8], 8'h0};
        default: data_word = data;
      endcase
    end
  end

  // Segment sequencing, word emission and checksum accumulation
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rem_d    = rem_q;
    acc_d    = acc_q;
    pkg_d    = pkg_q;
    wr_en_d  = wr_en_q;
    fin_d    = 1'b0;
    csum_d   = csum_q;
    word     = 32'h0;
    word_vld = 1'b0;
    data_rd  = 1'b0;
    if (ld) wr_en_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_HDR;
          idx_d   = 3'd0;
          acc_d   = 32'h0;
        end
      end
      S_HDR: begin
        if (ld) begin
          word     = hdr_word;
          word_vld = 1'b1;
          idx_d    = idx_q + 3'd1;
          if (idx_q == 3'd0 && PSEUDO_HDR != 0) acc_d = acc_q + pseudo_sum;
          if (idx_q == 3'd4) begin
            idx_d = 3'd0;
            rem_d = data_words;
            if (opt_n != 3'd0)                     state_d = S_OPT;
            else if (data_words != '0)             state_d = S_DATA;
            else                                   state_d = S_FOLD1;
          end
        end
      end
      S_OPT: begin
        if (ld) begin
          word     = opt_word;
          word_vld = 1'b1;
          idx_d    = idx_q + 3'd1;
          if (idx_q == opt_n - 3'd1) begin
            state_d = (data_words != '0) ? S_DATA : S_FOLD1;
          end
        end
      end
      S_DATA: begin
        data_rd = ld;
        if (ld && data_av) begin
          word     = data_word;
          word_vld = 1'b1;
          rem_d    = rem_q - REM_ONE;
          if (rem_q == REM_ONE) state_d = S_FOLD1;
        end
      end
      S_FOLD1: begin
        acc_d   = fold_acc;
        state_d = S_FOLD2;
      end
      S_FOLD2: begin
        acc_d = fold_acc;
        if (ld) begin
          state_d = S_DONE;
          fin_d   = 1'b1;
          csum_d  = ~fold_acc[15:0];
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (word_vld) begin
      pkg_d   = word;
      wr_en_d = 1'b1;
      acc_d   = acc_d + {16'h0, word[31:16]} + {16'h0, word[15:0]};
    end
  end

  // State, accumulator and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      pkg_q   <= '0;
      wr_en_q <= 1'b0;
      fin_q   <= 1'b0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      pkg_q   <= pkg_d;
      wr_en_q <= wr_en_d;
      fin_q   <= fin_d;
      csum_q  <= csum_d;
    end
  end

  assign pkg_data     = pkg_q;
  assign wr_en        = wr_en_q;
  assign checksum_out = csum_q;
  assign fin          = fin_q;

endmodule

// File: tb/tb_tcp_stream_encoder.sv
// tb/tb_tcp_stream_encoder.sv - self-checking bench for tcp_stream_encoder
module tb_tcp_stream_encoder;

  localparam int LEN_W  = 16;
  localparam int PSEUDO = 1;
`ifdef TCP_ENC_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, start;
  logic [15:0] src_port, dest_port, window, urg_ptr, mss;
  logic [31:0] seq_num, ack_num, src_ip, dst_ip, data;
  logic f_urg, f_ack, f_psh, f_rst, f_syn, f_fin;
  logic [2:0] option_av;
  logic [7:0] scale_wnd;
  logic [63:0] time_stp;
  logic [LEN_W-1:0] len;
  logic data_av, data_rd, out_rdy, wr_en, fin;
  logic [31:0] pkg_data;
  logic [15:0] checksum_out;

  tcp_stream_encoder #(.LEN_W(LEN_W), .PSEUDO_HDR(PSEUDO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_port(src_port), .dest_port(dest_port), .seq_num(seq_num), .ack_num(ack_num),
    .f_urg(f_urg), .f_ack(f_ack), .f_psh(f_psh), .f_rst(f_rst), .f_syn(f_syn), .f_fin(f_fin),
    .window(window), .urg_ptr(urg_ptr), .src_ip(src_ip), .dst_ip(dst_ip),
    .option_av(option_av), .mss(mss), .scale_wnd(scale_wnd), .time_stp(time_stp),
    .len(len), .data(data), .data_av(data_av), .data_rd(data_rd), .out_rdy(out_rdy),
    .pkg_data(pkg_data), .wr_en(wr_en), .checksum_out(checksum_out), .fin(fin)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [15:0] s_sp, s_dp, s_win, s_urg, s_mss;
  logic [31:0] s_seq, s_ack, s_sip, s_dip;
  logic [5:0]  s_flags;
  logic [2:0]  s_opt;
  logic [7:0]  s_scale;
  logic [63:0] s_ts;
  int          s_len;
  logic [7:0]  pay [0:71];

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [15:0] exp_csum;
  int cyc = 0, first_wr = -1, last_xfer = -1, fin_cyc = -1, dptr = 0;
  bit take = 1'b0, prev_stall = 1'b0, rnd = 1'b0;
  logic [31:0] prev_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pay_word(input int k);
    if (k > 17) return 32'h0;
    return {pay[4*k], pay[4*k+1], pay[4*k+2], pay[4*k+3]};
  endfunction

  // Reference: segment as a list of words built byte-wise, RFC 1071 sum with end-around carry
  task automatic build_expected();
    bit ts_on;
    int n_opt;
    logic [3:0] doff;
    logic [31:0] w;
    logic [15:0] low;
    longint sum;
    ts_on = TS_EN && s_opt[2];
    n_opt = int'(s_opt[0]) + int'(s_opt[1]) + (ts_on ? 3 : 0);
    doff  = 4'(5 + n_opt);
    exp_q.delete();
    exp_q.push_back({s_sp, s_dp});
    exp_q.push_back(s_seq);
    exp_q.push_back(s_ack);
    exp_q.push_back({doff, 6'b0, s_flags, s_win});
    exp_q.push_back({16'h0, s_urg});
    if (s_opt[0]) exp_q.push_back({16'h0204, s_mss});
    if (s_opt[1]) exp_q.push_back({8'h01, 8'h03, 8'h03, s_scale});
    if (ts_on) begin
      exp_q.push_back(32'h0101080A);
      exp_q.push_back(s_ts[63:32]);
      exp_q.push_back(s_ts[31:0]);
    end
    for (int i = 0; i < s_len; i += 4) begin
      w = '0;
      for (int b = 0; b < 4; b++) if (i + b < s_len) w[31-8*b -: 8] = pay[i+b];
      exp_q.push_back(w);
    end
    sum = 0;
    foreach (exp_q[k]) sum += longint'(exp_q[k][31:16]) + longint'(exp_q[k][15:0]);
    if (PSEUDO != 0) begin
      sum += longint'(s_sip[31:16]) + longint'(s_sip[15:0]);
      sum += longint'(s_dip[31:16]) + longint'(s_dip[15:0]);
      sum += 6 + 4 * longint'(doff) + longint'(s_len);
    end
    while (sum > 65535) sum = (sum & 65535) + (sum >> 16);
    low = 16'(sum);
    exp_csum = ~low;
  endtask

  task automatic drive_fields();
    src_port = s_sp; dest_port = s_dp; seq_num = s_seq; ack_num = s_ack;
    {f_urg, f_ack, f_psh, f_rst, f_syn, f_fin} = s_flags;
    window = s_win; urg_ptr = s_urg; src_ip = s_sip; dst_ip = s_dip;
    option_av = s_opt; mss = s_mss; scale_wnd = s_scale; time_stp = s_ts;
    len = 16'(s_len);
  endtask

  task automatic scramble();
    src_port = 16'($urandom); dest_port = 16'($urandom);
    seq_num = $urandom; ack_num = $urandom;
    {f_urg, f_ack, f_psh, f_rst, f_syn, f_fin} = 6'($urandom);
    window = 16'($urandom); urg_ptr = 16'($urandom);
    src_ip = $urandom; dst_ip = $urandom; option_av = 3'($urandom);
    mss = 16'($urandom); scale_wnd = 8'($urandom); time_stp = {$urandom, $urandom};
    len = 16'($urandom);
  endtask

  // One clock: observe at the falling edge, then drive just after the rising edge
  task automatic step();
    @(negedge clk);
    cyc++;
    if (prev_stall) chk("stall_hold", {31'h0, wr_en, pkg_data}, {31'h0, 1'b1, prev_data});
    if (wr_en && first_wr < 0) first_wr = cyc;
    if (wr_en && out_rdy) begin
      got_q.push_back(pkg_data);
      last_xfer = cyc;
    end
    if (fin) fin_cyc = cyc;
    take       = data_rd && data_av;
    prev_stall = wr_en && !out_rdy;
    prev_data  = pkg_data;
    @(posedge clk);
    #1;
    if (take) dptr++;
    data    = (dptr * 4 < s_len) ? pay_word(dptr) : $urandom;
    data_av = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    out_rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
  endtask

  task automatic begin_segment();
    build_expected();
    got_q.delete();
    first_wr = -1; last_xfer = -1; fin_cyc = -1; dptr = 0; prev_stall = 1'b0;
    drive_fields();
    data = pay_word(0); data_av = 1'b1; out_rdy = 1'b1; start = 1'b1;
    step();
  endtask

  task automatic run_segment(input string tag, input bit poke);
    bit poked;
    int c0;
    poked = 1'b0;
    begin_segment();
    c0 = cyc;
    start = 1'b0;
    scramble();
    for (int n = 0; n < 3000 && fin_cyc < 0; n++) begin
      if (poke && !poked && got_q.size() >= 3) begin
        start = 1'b1;
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    chk({tag, "_fin_seen"}, 64'(fin_cyc >= 0), 64'd1);
    chk({tag, "_first_word_lat"}, 64'(first_wr - c0), 64'd2);
    chk({tag, "_word_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    chk({tag, "_checksum"}, 64'(checksum_out), 64'(exp_csum));
    if (!rnd) chk({tag, "_fin_lat"}, 64'(fin_cyc - last_xfer), 64'd2);
    chk({tag, "_fin_pulse"}, 64'(fin), 64'd0);
  endtask

  task automatic set_zero();
    s_sp = '0; s_dp = '0; s_seq = '0; s_ack = '0; s_flags = '0; s_win = '0; s_urg = '0;
    s_sip = '0; s_dip = '0; s_opt = '0; s_mss = '0; s_scale = '0; s_ts = '0; s_len = 0;
    for (int i = 0; i < 72; i++) pay[i] = 8'($urandom);
  endtask

  task automatic set_hello();
    string h;
    h = "Hello World";
    set_zero();
    s_sp = 16'hA08F; s_dp = 16'h2694; s_seq = 32'd1; s_ack = 32'd2;
    s_flags = 6'b010000; s_win = 16'd3; s_urg = 16'd4;
    s_sip = 32'hC0A80001; s_dip = 32'hC0A800C8; s_len = 11;
    for (int i = 0; i < 11; i++) pay[i] = h[i];
    pay[11] = 8'hA5;
  endtask

  task automatic set_random();
    s_sp = 16'($urandom); s_dp = 16'($urandom); s_seq = $urandom; s_ack = $urandom;
    s_flags = 6'($urandom); s_win = 16'($urandom); s_urg = 16'($urandom);
    s_sip = $urandom; s_dip = $urandom; s_opt = 3'($urandom);
    s_mss = 16'($urandom); s_scale = 8'($urandom); s_ts = {$urandom, $urandom};
    s_len = int'($urandom_range(0, 40));
    for (int i = 0; i < 72; i++) pay[i] = 8'($urandom);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; data = '0; data_av = 1'b0; out_rdy = 1'b1;
    set_zero();
    drive_fields();
    #1 reset = 1'b1;
    #1;
    chk("rst_pkg_data", 64'(pkg_data), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_data_rd", 64'(data_rd), 64'd0);
    chk("rst_checksum", 64'(checksum_out), 64'd0);
    chk("rst_fin", 64'(fin), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    rnd = 1'b0;
    set_zero();
    run_segment("zero", 1'b0);
    chk("zero_csum_const", 64'(checksum_out), 64'h AFE5);

    set_hello();
    run_segment("hello", 1'b0);
    chk("hello_last_word", 64'(got_q[7]), 64'h726C6400);

    set_zero();
    s_flags = 6'b000010; s_win = 16'd3; s_mss = 16'd1460; s_scale = 8'd7; s_opt = 3'b011;
    run_segment("opt", 1'b0);
    chk("opt_hdr_word3", 64'(got_q[3]), 64'h70020003);
    chk("opt_mss_word", 64'(got_q[5]), 64'h020405B4);
    chk("opt_ws_word", 64'(got_q[6]), 64'h01030307);

    s_opt = 3'b111; s_ts = 64'h1234_1234_1234_1234;
    run_segment("opt_ts", 1'b0);

    rnd = 1'b1;
    set_hello();
    run_segment("hello_bp", 1'b0);
    for (int t = 0; t < 8; t++) begin
      set_random();
      run_segment($sformatf("rnd%0d", t), 1'b0);
    end
    rnd = 1'b0;
    data_av = 1'b1; out_rdy = 1'b1;

    set_hello();
    run_segment("ign_start", 1'b1);

    set_hello();
    begin_segment();
    start = 1'b0;
    for (int n = 0; n < 100 && got_q.size() < 6; n++) step();
    chk("rstmid_pre_word", 64'(pkg_data), 64'(exp_q[6]));
    chk("rstmid_pre_rd", 64'(data_rd), 64'd1);
    reset = 1'b1;
    #1;
    chk("rstmid_pkg_data", 64'(pkg_data), 64'd0);
    chk("rstmid_wr_en", 64'(wr_en), 64'd0);
    chk("rstmid_data_rd", 64'(data_rd), 64'd0);
    chk("rstmid_checksum", 64'(checksum_out), 64'd0);
    chk("rstmid_fin", 64'(fin), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    prev_stall = 1'b0;
    run_segment("after_rst", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
